// File: rtl/switch_conditioner.sv
// Board switch conditioner: two-flop synchroniser, per-bit debounce and rise/fall pulses.
// Define SWITCH_ACTIVE_LOW_EN for switches wired to ground (pin low reads as 1).
module switch_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] raw_switch,
    output logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_e;

    logic [WIDTH-1:0] pin_lvl;
    logic [WIDTH-1:0] sync1_p0;
    logic [WIDTH-1:0] sync2_p1;
    logic [CNT_W-1:0] cnt_p2  [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] upd;
    deb_state_e       st;

`ifdef SWITCH_ACTIVE_LOW_EN
    assign pin_lvl = ~raw_switch;
`else
    assign pin_lvl = raw_switch;
`endif

    // Stage p2: per-bit debounce decision; PENDING is simply "synced level != output"
    always_comb begin
        upd = '0;
        st  = STABLE;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            st = (sync2_p1[i] != switch[i]) ? PENDING : STABLE;
            case (st)
                STABLE: cnt_nxt[i] = '0;
                PENDING: begin
                    if (cnt_p2[i] == CNT_LAST) begin
                        upd[i]     = 1'b1;
                        cnt_nxt[i] = '0;
                    end else begin
                        cnt_nxt[i] = cnt_p2[i] + CNT_W'(1);
                    end
                end
                default: cnt_nxt[i] = '0;
            endcase
        end
    end

    // Stages p0/p1 synchronise; pulses register on the same edge that moves switch
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            sync1_p0 <= '0;
            sync2_p1 <= '0;
            switch   <= '0;
            rise     <= '0;
            fall     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_p2[i] <= '0;
            end
        end else begin
            sync1_p0 <= pin_lvl;
            sync2_p1 <= sync1_p0;
            switch   <= switch ^ upd;
            rise     <= upd & sync2_p1;
            fall     <= upd & ~sync2_p1;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_p2[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Input-side conditioner between the board switch pins and the io bus `switch` field.
- Synchronises raw asynchronous switch levels into the system clock domain, then debounces each bit independently.
- Presents clean levels plus one-cycle rise/fall pulses, so CPU-side logic sees a glitch-free switch value.
- Instantiated at top level next to the prescaler; clocked by the same (slow) system clock as the mother board.

Parameters:
- WIDTH, 4, number of switch bits.
- DEBOUNCE_CYCLES, 1_000_000, consecutive mismatching clock edges required before a bit's output changes; legal range >= 1.

Ports:
- clock  input  1  system clock.
- n_reset  input  1  asynchronous active-low reset.
- raw_switch  input  WIDTH  unsynchronised switch pin levels.
- switch  output  WIDTH  debounced, synchronised switch levels.
- rise  output  WIDTH  one-cycle pulse per bit when `switch` goes 0->1.
- fall  output  WIDTH  one-cycle pulse per bit when `switch` goes 1->0.

Behaviour:
- Reset and clocking (already decided):
  - One clock, `clock`.
  - `n_reset` is asynchronous, active-low.
  - While `n_reset` = 0, all flops clear immediately: sync stages, counters, `switch`, `rise`, `fall` all = 0.
  - Deassertion is not internally synchronised; the top level guarantees release timing.
- Synchroniser:
  - Two-flop chain per bit: sync1 <= raw_switch; sync2 <= sync1.
  - Only sync2 feeds the debounce logic.
- Debounce, per bit i, with an independent counter of width $clog2(DEBOUNCE_CYCLES):
  - Two states: STABLE (sync2[i] == switch[i]) and PENDING (they differ).
  - STABLE: counter held at 0.
  - PENDING, counter < DEBOUNCE_CYCLES-1: counter increments.
  - PENDING, counter == DEBOUNCE_CYCLES-1: on that edge, switch[i] <= sync2[i], counter <= 0.
  - Any edge on which sync2[i] matches switch[i] again (bounce): counter <= 0, back to STABLE, no output change.
- Latency: a raw level held steady from its first sampling edge updates `switch` on edge DEBOUNCE_CYCLES+2, counting the sampling edge as edge 1.
- Edge pulses:
  - rise[i]/fall[i] are registered and assert during exactly the cycle after the edge that updates switch[i].
  - rise[i] asserts only for 0->1; fall[i] only for 1->0.
  - rise[i] and fall[i] are never simultaneously high.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- DEBOUNCE_CYCLES == 1: the first mismatching edge updates the output; latency 3 edges.
- Independence: bits are fully independent. Simultaneous changes on several bits with identical timing update on the same edge and pulse together.
- Reset mid-count: pending state is lost; after release every bit restarts from 0 and a held-high input is re-debounced from scratch.
- Reset while an input is held high after release: `switch` rises DEBOUNCE_CYCLES+2 edges later and `rise` pulses. This is intended.

Optional Feature:
- Macro: SWITCH_ACTIVE_LOW_EN.
- When defined: raw_switch is inverted before sync1, for board switches wired to ground.
  - `switch` reports 1 while the pin is low.
  - Reset values are unchanged (all 0). With the pin held low through reset, `switch` rises after the normal latency once reset is released.
- When undefined: raw_switch is used non-inverted.
- Ports and timing are identical in both builds.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=4):
- Reset, raw_switch=4'b0000, release, run 20 cycles -> `switch`, `rise`, `fall` stay 4'b0000.
- raw_switch 0->4'b0001, held -> switch=4'b0001 appears on edge 6 after the sampling edge; rise=4'b0001 for exactly one cycle; fall stays 0.
- raw_switch[0] toggles 1,0,1,0 every 2 cycles, then stays 0 -> `switch` never changes, no pulses.
- raw_switch=4'b1010 stable, then switch=4'b1010, then raw_switch=4'b0000 -> fall=4'b1010 pulses once, 6 edges after the change.
- Raw bit held high; assert n_reset asynchronously after the counter reaches 2 -> outputs drop to 0 immediately, before the next clock edge; after release, switch=1 only after a full 6-edge latency.
- SWITCH_ACTIVE_LOW_EN build: raw_switch=4'b1110 held -> switch=4'b0001 after 6 edges, rise=4'b0001 pulses once.
